coreaxitoahbl_rd_resp_pack: RTL
===============================

# coreaxitoahbl_rd_resp_pack

Read-response packer for the AXI-to-AHB-Lite bridge. It collects 32-bit AHB-Lite read data phases, packs them into 64-bit AXI read beats, and tags each beat with RID, RRESP and RLAST. Beats are buffered in a 2-entry FIFO. It drives the `RxxxOut` inputs of the AXI output register stage, which presents them to the AXI master one ACLK later. The registered RVALID is fed back so that beats are popped on the real AXI handshake.

## Interface
- ID_WIDTH, 4, width of AXI ID fields
- ACLK  in  1  clock
- ARESETN  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  read command offered (accepted when cmd_valid & cmd_ready)
- cmd_ready  out  1  high in IDLE only
- cmd_id  in  ID_WIDTH  ARID of burst
- cmd_len  in  4  ARLEN (beats-1, 0..15)
- cmd_size  in  3  ARSIZE; only 3'd2 (32-bit) and 3'd3 (64-bit) are legal
- cmd_addr2  in  1  ARADDR[2] of first beat
- ahb_rvalid  in  1  one completed AHB read data phase this cycle
- ahb_rdata  in  32  HRDATA of that phase
- ahb_err  in  1  HRESP error on that phase
- ahb_rd_ready  out  1  FIFO count < 2; AHB control issues data phases only while high
- ovf_err  out  1  sticky; set if ahb_rvalid arrives while ahb_rd_ready low
- RVALID  in  1  registered RVALID as seen by the AXI master
- RREADY  in  1  AXI master RREADY
- RVALIDOut, RLASTOut  out  1  next-cycle RVALID/RLAST
- RDATAOut  out  64  next-cycle RDATA
- RIDOut  out  ID_WIDTH  next-cycle RID
- RRESPOut  out  2  next-cycle RRESP

## Operation
- State machine: IDLE, LOW, HIGH.
  - IDLE: cmd_ready=1. On accept, latch id/len/size/addr2, clear beat counter, go to LOW.
  - LOW: on ahb_rvalid, store the word in the lane given by current addr2 (addr2=0 → [31:0], addr2=1 → [63:32]).
    - If size=2, or size=3 with addr2=1 (unaligned first beat), the beat is complete: push it.
    - Otherwise go to HIGH.
  - HIGH: on ahb_rvalid, store the word in [63:32] and push the beat; go to LOW.
  - After pushing the beat with counter == len, go to IDLE. Otherwise increment the counter and stay in or return to LOW.
- Lane advance:
  - size=2: addr2 toggles after every beat.
  - size=3: addr2 is forced to 0 after the first beat.
  - Unwritten lanes are zero.
- A beat's RRESP is 2'b10 if any of its words had ahb_err, else 2'b00. RLAST = (counter == len). Errors do not terminate the burst.
- FIFO entry holds {data, id, resp, last}; depth 2.
- pop = RVALID & RREADY. A pop always removes the head entry.
- Out selection:
  - Out signals = entry[1] if pop, else entry[0].
  - RVALIDOut = (count − pop) > 0.
  - When RVALIDOut=0, all Out fields are 0.
- Push and pop in the same cycle: count unchanged, ordering preserved.
- A word arriving while count==2 is discarded, FIFO is unchanged, and ovf_err is set. ovf_err clears only on reset.
- Illegal cmd_size: treated as 3'd3.

## Timing
- Reset: state IDLE, FIFO empty, cmd_ready=1, ahb_rd_ready=1, ovf_err=0, all Out signals 0.
- Reset mid-burst discards all state and buffered beats.
- Word completing a beat arrives in cycle N:
  - pushed at the end of N;
  - RVALIDOut=1 during N+1;
  - RVALID visible at the AXI master in N+2.
- Out signals are combinational from FIFO state and RVALID/RREADY. There is no other combinational path.
- The next command is accepted in the cycle after the last push. Beats of the previous burst may still be in the FIFO.
- Sustained throughput with RREADY=1: one 32-bit beat per cycle, or one 64-bit beat per 2 cycles.

## Test plan
- Reset values: assert ARESETN low mid-burst with 2 beats queued → on release, RVALIDOut=0, ahb_rd_ready=1, cmd_ready=1, ovf_err=0.
- 64-bit aligned burst: len=3, size=3, addr2=0, id=5, words 0x1..0x8 with RREADY=1 → 4 beats:
  - RDATA 0x00000002_00000001 … 0x00000008_00000007;
  - RID=5, RLAST only on beat 4, RRESP=0.
- 32-bit burst: len=2, size=2, addr2=1, words A, B, C → RDATA A<<32, B, C<<32; RLAST on beat 3.
- Unaligned 64-bit burst: size=3, addr2=1, len=1, words X, Y, Z → beat 1 = X<<32; beat 2 = {Z, Y}.
- Error on word 2 of len=1, size=3 → beat 1 RRESP=2'b10, beat 2 RRESP=2'b00, burst completes.
- Backpressure: RREADY=0 with 3 words offered at size=2 →
  - ahb_rd_ready falls after 2 pushes;
  - forced third word sets ovf_err and the FIFO keeps 2 entries;
  - releasing RREADY yields the 2 beats in order.

Source files
------------

// File: rtl/coreaxitoahbl_rd_resp_pack.sv
// Read-response packer: gathers 32-bit AHB-Lite read data phases into 64-bit
// AXI read beats tagged with RID/RRESP/RLAST, buffered in a 2-entry FIFO that
// feeds the AXI output register stage combinationally.
module coreaxitoahbl_rd_resp_pack #(
    parameter int ID_WIDTH = 4
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ID_WIDTH-1:0] cmd_id,
    input  logic [3:0]          cmd_len,
    input  logic [2:0]          cmd_size,
    input  logic                cmd_addr2,
    input  logic                ahb_rvalid,
    input  logic [31:0]         ahb_rdata,
    input  logic                ahb_err,
    output logic                ahb_rd_ready,
    output logic                ovf_err,
    input  logic                RVALID,
    input  logic                RREADY,
    output logic                RVALIDOut,
    output logic                RLASTOut,
    output logic [63:0]         RDATAOut,
    output logic [ID_WIDTH-1:0] RIDOut,
    output logic [1:0]          RRESPOut
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    // FIFO entry layout: {data[63:0], id, resp[1:0], last}
    localparam int EW = 64 + ID_WIDTH + 2 + 1;

    logic [1:0]          state_q, state_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [3:0]          len_q, len_d;
    logic                size64_q, size64_d;
    logic                addr2_q, addr2_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [63:0]         data_q, data_d;
    logic                err_q, err_d;
    logic                ovf_err_q, ovf_err_d;
    logic [1:0]          count_q, count_d;
    logic [EW-1:0]       fifo0_q, fifo0_d;
    logic [EW-1:0]       fifo1_q, fifo1_d;

    logic                word_ok_s;
    logic                complete_s;
    logic                last_s;
    logic [63:0]         beat_data_s;
    logic                beat_err_s;
    logic [EW-1:0]       push_entry_s;
    logic                push_s;
    logic                pop_s;
    logic                out_valid_s;
    logic [EW-1:0]       head_s;

    assign cmd_ready    = (state_q == ST_IDLE);
    assign ahb_rd_ready = (count_q != 2'd2);
    assign ovf_err      = ovf_err_q;

    // Burst sequencing: lane placement of each AHB word and beat completion.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        len_d       = len_q;
        size64_d    = size64_q;
        addr2_d     = addr2_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        err_d       = err_q;
        complete_s  = 1'b0;
        beat_data_s = 64'd0;
        beat_err_s  = 1'b0;
        word_ok_s   = ahb_rvalid & ahb_rd_ready;
        ovf_err_d   = ovf_err_q | (ahb_rvalid & ~ahb_rd_ready);
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    id_d     = cmd_id;
                    len_d    = cmd_len;
                    // Anything other than a 32-bit transfer is handled as 64-bit.
                    size64_d = (cmd_size != 3'd2);
                    addr2_d  = cmd_addr2;
                    cnt_d    = 4'd0;
                    data_d   = 64'd0;
                    err_d    = 1'b0;
                    state_d  = ST_LOW;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (word_ok_s) begin
                    if (addr2_q) begin
                        complete_s  = 1'b1;
                        beat_data_s = {ahb_rdata, 32'd0};
                        beat_err_s  = ahb_err;
                    end else if (!size64_q) begin
                        complete_s  = 1'b1;
                        beat_data_s = {32'd0, ahb_rdata};
                        beat_err_s  = ahb_err;
                    end else begin
                        data_d  = {32'd0, ahb_rdata};
                        err_d   = ahb_err;
                        state_d = ST_HIGH;
                    end
                end else begin
                    state_d = ST_LOW;
                end
            end
            ST_HIGH: begin
                if (word_ok_s) begin
                    complete_s  = 1'b1;
                    beat_data_s = {ahb_rdata, data_q[31:0]};
                    beat_err_s  = err_q | ahb_err;
                end else begin
                    state_d = ST_HIGH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        last_s = (cnt_q == len_q);
        if (complete_s) begin
            data_d  = 64'd0;
            err_d   = 1'b0;
            // 32-bit beats alternate lanes; 64-bit beats realign to lane 0.
            addr2_d = size64_q ? 1'b0 : ~addr2_q;
            if (last_s) begin
                state_d = ST_IDLE;
            end else begin
                cnt_d   = cnt_q + 4'd1;
                state_d = ST_LOW;
            end
        end else begin
            addr2_d = addr2_d;
        end
        push_s       = complete_s;
        push_entry_s = {beat_data_s, id_q, (beat_err_s ? 2'b10 : 2'b00), last_s};
    end

    // FIFO bookkeeping: entry 0 is the head; a pop shifts entry 1 down.
    always_comb begin
        pop_s   = RVALID & RREADY & (count_q != 2'd0);
        count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
        fifo0_d = fifo0_q;
        fifo1_d = fifo1_q;
        case ({push_s, pop_s})
            2'b10: begin
                if (count_q == 2'd0) begin
                    fifo0_d = push_entry_s;
                end else begin
                    fifo1_d = push_entry_s;
                end
            end
            2'b01: begin
                fifo0_d = fifo1_q;
                fifo1_d = {EW{1'b0}};
            end
            2'b11: begin
                // Push needs a free slot, so a simultaneous pop leaves one entry.
                fifo0_d = push_entry_s;
                fifo1_d = {EW{1'b0}};
            end
            default: begin
                fifo0_d = fifo0_q;
                fifo1_d = fifo1_q;
            end
        endcase
    end

    // Next-cycle AXI R channel: the entry that will be at the head after this pop.
    always_comb begin
        head_s      = pop_s ? fifo1_q : fifo0_q;
        out_valid_s = ((count_q - {1'b0, pop_s}) != 2'd0);
        if (out_valid_s) begin
            RVALIDOut = 1'b1;
            RDATAOut  = head_s[EW-1 -: 64];
            RIDOut    = head_s[ID_WIDTH+2 : 3];
            RRESPOut  = head_s[2:1];
            RLASTOut  = head_s[0];
        end else begin
            RVALIDOut = 1'b0;
            RDATAOut  = 64'd0;
            RIDOut    = {ID_WIDTH{1'b0}};
            RRESPOut  = 2'b00;
            RLASTOut  = 1'b0;
        end
    end

    // State and FIFO registers; reset drops any burst in flight and all beats.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= ST_IDLE;
            id_q      <= {ID_WIDTH{1'b0}};
            len_q     <= 4'd0;
            size64_q  <= 1'b0;
            addr2_q   <= 1'b0;
            cnt_q     <= 4'd0;
            data_q    <= 64'd0;
            err_q     <= 1'b0;
            ovf_err_q <= 1'b0;
            count_q   <= 2'd0;
            fifo0_q   <= {EW{1'b0}};
            fifo1_q   <= {EW{1'b0}};
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            len_q     <= len_d;
            size64_q  <= size64_d;
            addr2_q   <= addr2_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            err_q     <= err_d;
            ovf_err_q <= ovf_err_d;
            count_q   <= count_d;
            fifo0_q   <= fifo0_d;
            fifo1_q   <= fifo1_d;
        end
    end

endmodule
